// File: rtl/icon_pkg.sv
// icon_pkg: shared definitions for the Rojobot display path.
//   ICON_SIZE         sprite edge length in screen pixels
//   heading_e         bot heading codes HEAD_N..HEAD_NW
//   ICON_*            2-bit icon codes consumed by the colorizer
//   WORLD_*           2-bit world-map pixel codes consumed by the colorizer
//   bot_pose_t        location + heading as held in staging/active registers
//   rotate_src        source (sr,sc) in a base image for output (r,c)
package icon_pkg;

   localparam int unsigned ICON_SIZE = 16;

   typedef enum logic [2:0] {
      HEAD_N  = 3'd0,
      HEAD_NE = 3'd1,
      HEAD_E  = 3'd2,
      HEAD_SE = 3'd3,
      HEAD_S  = 3'd4,
      HEAD_SW = 3'd5,
      HEAD_W  = 3'd6,
      HEAD_NW = 3'd7
   } heading_e;

   localparam logic [1:0] ICON_TRANSPARENT = 2'b00;
   localparam logic [1:0] ICON_C1          = 2'b01;
   localparam logic [1:0] ICON_C2          = 2'b10;
   localparam logic [1:0] ICON_C3          = 2'b11;

   localparam logic [1:0] WORLD_BACKGROUND  = 2'b00;
   localparam logic [1:0] WORLD_LINE        = 2'b01;
   localparam logic [1:0] WORLD_OBSTRUCTION = 2'b10;
   localparam logic [1:0] WORLD_RESERVED    = 2'b11;

   typedef struct packed {
      logic [6:0] x;
      logic [6:0] y;
      heading_e   orient;
   } bot_pose_t;

   // Clockwise quarter turns; returns {sr, sc}.
   function automatic logic [7:0] rotate_src(input logic [1:0] q,
                                             input logic [3:0] r,
                                             input logic [3:0] c);
      logic [7:0] src;
      case (q)
         2'd0:    src = {r, c};
         2'd1:    src = {4'd15 - c, r};
         2'd2:    src = {4'd15 - r, 4'd15 - c};
         default: src = {c, 4'd15 - r};
      endcase
      return src;
   endfunction

endpackage

// File: rtl/icon_rom.sv
// icon_rom: synchronous-read sprite ROM, 2 images x 16x16 x 2 bits.
//   clock  in   pixel clock
//   rst    in   synchronous active-high reset, clears the output register
//   en     in   1 = pixel is inside the window and video is on
//   addr   in   {base, sr[3:0], sc[3:0]}
//   data   out  registered icon code (transparent when en was 0)
module icon_rom
   import icon_pkg::*;
(
   input  logic       clock,
   input  logic       rst,
   input  logic       en,
   input  logic [8:0] addr,
   output logic [1:0] data
);

   // One 32-bit word per sprite row; column 0 is the leftmost (MS) pixel.
   localparam logic [31:0] IMG [2][16] = '{
      '{ // heading N
         32'h0003_C000, 32'h000F_F000, 32'h003F_FC00, 32'h00FD_7F00,
         32'h03F5_5FC0, 32'h0FD5_57F0, 32'h0015_5E00, 32'h0015_5400,
         32'h0016_9400, 32'h001A_A400, 32'h001A_A400, 32'h0016_9400,
         32'h0D15_5400, 32'h0055_5500, 32'h0154_1540, 32'h0500_0050
      },
      '{ // heading NE
         32'h0000_03FF, 32'h0000_0FFF, 32'h0000_3F7F, 32'h0000_FD7F,
         32'h0003_F57F, 32'h000F_D5F3, 32'h0035_57C3, 32'h00D5_5F03,
         32'h0355_7C00, 32'h0D55_7000, 32'h3559_4000, 32'h15A5_0000,
         32'h1A94_0000, 32'h0550_0000, 32'h0540_0000, 32'h2100_0000
      }
   };

   logic [31:0] row_bits;
   logic [1:0]  data_d, data_q;

   always_comb begin
      row_bits = IMG[addr[8]][addr[7:4]];
      data_d   = ICON_TRANSPARENT;
      if (en) begin
         data_d = row_bits[{~addr[3:0], 1'b0} +: 2];
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/bot_icon.sv
// bot_icon: 2-bit Rojobot sprite pixel for the colorizer icon input.
//   clock         in   25 MHz pixel clock
//   rst           in   synchronous active-high reset
//   video_on      in   1 = active video area
//   pixel_row     in   current display row
//   pixel_column  in   current display column
//   loc_x, loc_y  in   bot world location (0..127)
//   orient        in   bot heading (0=N .. 7=NW)
//   upd_sysregs   in   one-cycle pulse: loc_x/loc_y/orient valid
//   icon          out  icon code, 2 cycles after pixel_row/pixel_column
module bot_icon
   import icon_pkg::*;
#(
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned ICON_OFFSET = 6,
   parameter int unsigned COMMIT_ROW  = 480
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       video_on,
   input  logic [9:0] pixel_row,
   input  logic [9:0] pixel_column,
   input  logic [6:0] loc_x,
   input  logic [6:0] loc_y,
   input  logic [2:0] orient,
   input  logic       upd_sysregs,
   output logic [1:0] icon
);

   bot_pose_t  pose_in;
   bot_pose_t  stg_d, stg_q, act_d, act_q;
   logic       pend_d, pend_q;
   logic       commit_slot;

   logic [10:0] org_c, org_r, dc, dr;
   logic [2:0]  act_head;
   logic [7:0]  src;

   logic       in_win_d, in_win_q;
   logic       vid_d, vid_q;
   logic       base_d, base_q;
   logic [3:0] sr_d, sr_q, sc_d, sc_q;

   assign pose_in     = '{x: loc_x, y: loc_y, orient: heading_e'(orient)};
   assign commit_slot = (pixel_row == 10'(COMMIT_ROW)) && (pixel_column == '0);

   // Double-buffered pose: staging takes every update, active only changes
   // in the commit slot so a frame is always drawn from one consistent pose.
   always_comb begin
      stg_d  = stg_q;
      act_d  = act_q;
      pend_d = pend_q;
      if (commit_slot && upd_sysregs) begin
         stg_d  = pose_in;
         act_d  = pose_in;
         pend_d = 1'b0;
      end else if (commit_slot && pend_q) begin
         act_d  = stg_q;
         pend_d = 1'b0;
      end else if (upd_sysregs) begin
         stg_d  = pose_in;
         pend_d = 1'b1;
      end
   end

   // Modular 11-bit arithmetic: a negative offset appears as a large
   // unsigned value, so one unsigned compare covers 0 <= d < 16.
   always_comb begin
      org_c    = ({4'b0000, act_q.x} << SCALE_SHIFT) - 11'(ICON_OFFSET);
      org_r    = ({4'b0000, act_q.y} << SCALE_SHIFT) - 11'(ICON_OFFSET);
      dc       = {1'b0, pixel_column} - org_c;
      dr       = {1'b0, pixel_row} - org_r;
      act_head = act_q.orient;
      src      = rotate_src(act_head[2:1], dr[3:0], dc[3:0]);
      in_win_d = (dc < 11'(ICON_SIZE)) && (dr < 11'(ICON_SIZE));
      vid_d    = video_on;
      base_d   = act_head[0];
      sr_d     = src[7:4];
      sc_d     = src[3:0];
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         stg_q    <= '0;
         act_q    <= '0;
         pend_q   <= 1'b0;
         in_win_q <= 1'b0;
         vid_q    <= 1'b0;
         base_q   <= 1'b0;
         sr_q     <= '0;
         sc_q     <= '0;
      end else begin
         stg_q    <= stg_d;
         act_q    <= act_d;
         pend_q   <= pend_d;
         in_win_q <= in_win_d;
         vid_q    <= vid_d;
         base_q   <= base_d;
         sr_q     <= sr_d;
         sc_q     <= sc_d;
      end
   end

   icon_rom u_rom (
      .clock (clock),
      .rst   (rst),
      .en    (in_win_q & vid_q),
      .addr  ({base_q, sr_q, sc_q}),
      .data  (icon)
   );

endmodule

// File: tb/tb_bot_icon.sv
module tb_bot_icon;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       video_on = 1'b0;
   logic [9:0] pixel_row = '0;
   logic [9:0] pixel_column = '0;
   logic [6:0] loc_x = '0;
   logic [6:0] loc_y = '0;
   logic [2:0] orient = '0;
   logic       upd_sysregs = 1'b0;
   logic [1:0] icon;

   always #20 clock = ~clock;

   bot_icon #(.SCALE_SHIFT(2), .ICON_OFFSET(6), .COMMIT_ROW(480)) dut (
      .clock        (clock),
      .rst          (rst),
      .video_on     (video_on),
      .pixel_row    (pixel_row),
      .pixel_column (pixel_column),
      .loc_x        (loc_x),
      .loc_y        (loc_y),
      .orient       (orient),
      .upd_sysregs  (upd_sysregs),
      .icon         (icon)
   );

   // Sprite images, one word per row, column 0 in bits [31:30].
   logic [31:0] spr_n  [16] = '{
      32'h0003_C000, 32'h000F_F000, 32'h003F_FC00, 32'h00FD_7F00,
      32'h03F5_5FC0, 32'h0FD5_57F0, 32'h0015_5E00, 32'h0015_5400,
      32'h0016_9400, 32'h001A_A400, 32'h001A_A400, 32'h0016_9400,
      32'h0D15_5400, 32'h0055_5500, 32'h0154_1540, 32'h0500_0050};
   logic [31:0] spr_ne [16] = '{
      32'h0000_03FF, 32'h0000_0FFF, 32'h0000_3F7F, 32'h0000_FD7F,
      32'h0003_F57F, 32'h000F_D5F3, 32'h0035_57C3, 32'h00D5_5F03,
      32'h0355_7C00, 32'h0D55_7000, 32'h3559_4000, 32'h15A5_0000,
      32'h1A94_0000, 32'h0550_0000, 32'h0540_0000, 32'h2100_0000};

   int checks = 0;
   int errors = 0;

   // Reference model state: pose drawn this frame, staged pose, pending flag.
   int act_x = 0, act_y = 0, act_o = 0;
   int stg_x = 0, stg_y = 0, stg_o = 0;
   bit pend = 0;

   int    expq[$];
   string tagq[$];

   task automatic check_eq(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int sprite_px(input int base, input int r, input int c);
      logic [31:0] w;
      w = (base != 0) ? spr_ne[r] : spr_n[c < 0 ? 0 : r];
      return int'((w >> (30 - 2 * c)) & 32'd3);
   endfunction

   // Expected icon for a pixel given the pose currently committed.
   function automatic int model_px(input int row, input int col, input bit von);
      int r, c, t;
      r = row - (act_y * 4 - 6);
      c = col - (act_x * 4 - 6);
      if (!von || r < 0 || r > 15 || c < 0 || c > 15) return 0;
      // Rotate clockwise one quarter turn at a time.
      for (int k = 0; k < act_o / 2; k++) begin
         t = r;
         r = 15 - c;
         c = t;
      end
      return sprite_px(act_o % 2, r, c);
   endfunction

   task automatic drive(input string tag, input bit r, input int row, input int col,
                        input bit von, input bit upd, input int lx, input int ly,
                        input int lo);
      @(negedge clock);
      if (expq.size() == 2) check_eq(tagq.pop_front(), int'(icon), expq.pop_front());
      rst          = r;
      pixel_row    = 10'(row);
      pixel_column = 10'(col);
      video_on     = von;
      upd_sysregs  = upd;
      loc_x        = 7'(lx);
      loc_y        = 7'(ly);
      orient       = 3'(lo);
      if (r && expq.size() > 0) expq[expq.size() - 1] = 0;
      expq.push_back(r ? 0 : model_px(row, col, von));
      tagq.push_back(tag);
      if (r) begin
         act_x = 0; act_y = 0; act_o = 0;
         stg_x = 0; stg_y = 0; stg_o = 0;
         pend  = 0;
      end else if (row == 480 && col == 0 && upd) begin
         act_x = lx; act_y = ly; act_o = lo;
         stg_x = lx; stg_y = ly; stg_o = lo;
         pend  = 0;
      end else if (row == 480 && col == 0 && pend) begin
         act_x = stg_x; act_y = stg_y; act_o = stg_o;
         pend  = 0;
      end else if (upd) begin
         stg_x = lx; stg_y = ly; stg_o = lo;
         pend  = 1;
      end
   endtask

   task automatic idle(input string tag, input int row, input int col, input bit von);
      drive(tag, 0, row, col, von, 0, 0, 0, 0);
   endtask

   task automatic sweep(input string tag, input int r0, input int c0, input int n);
      for (int r = r0; r < r0 + n; r++)
         for (int c = c0; c < c0 + n; c++)
            idle(tag, r, c, 1);
   endtask

   task automatic commit_pose(input int x, input int y, input int o);
      drive("upd", 0, 300, 17, 1, 1, x, y, o);
      idle("pre_commit", 479, 700, 0);
      idle("commit", 480, 0, 0);
   endtask

   initial begin
      int row, col;
      for (int i = 0; i < 3; i++)
         drive("reset", 1, $urandom_range(1023), $urandom_range(1023), 1, 0, 0, 0, 0);
      sweep("clip_origin", 0, 0, 16);

      for (int o = 0; o < 8; o++) begin
         commit_pose(32, 32, o);
         sweep("heading", 118, 118, 24);
      end
      idle("edge_above", 121, 130, 1);
      idle("edge_right", 130, 138, 1);

      commit_pose(32, 32, 0);
      drive("mid_upd", 0, 200, 5, 1, 1, 64, 32, 0);
      sweep("old_frame", 120, 120, 20);
      idle("commit", 480, 0, 0);
      sweep("new_frame", 120, 246, 24);

      drive("coincident", 0, 480, 0, 0, 1, 10, 32, 0);
      sweep("coincident_frame", 118, 30, 24);
      idle("empty_commit", 480, 0, 0);
      sweep("coincident_hold", 122, 34, 16);

      commit_pose(32, 32, 3);
      for (int i = 0; i < 12; i++) idle("video_gate", 130, 130, i[1]);

      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(99) < 80) begin
            row = act_y * 4 - 10 + int'($urandom_range(23));
            col = act_x * 4 - 10 + int'($urandom_range(23));
            if (row < 0) row = 0;
            if (col < 0) col = 0;
         end else begin
            row = $urandom_range(1023);
            col = $urandom_range(1023);
         end
         if ($urandom_range(99) < 3) begin
            row = 480;
            col = 0;
         end
         drive("random", $urandom_range(999) < 2, row, col, $urandom_range(9) != 0,
               $urandom_range(99) < 4, $urandom_range(127), $urandom_range(127),
               $urandom_range(7));
      end

      idle("drain", 0, 1023, 0);
      idle("drain", 0, 1023, 0);
      idle("drain", 0, 1023, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bot_icon.md
Name: bot_icon

Overview:
- Generates the 2-bit icon pixel code for the Rojobot sprite; this is the code the colorizer consumes on its icon input.
- Compares the current display pixel position against the bot's world location, scaled 4x, and fetches the pixel from a 16x16 sprite.
- The sprite is rotated and selected according to the bot heading.
- Location and heading updates are double-buffered and committed only in vertical blanking, so the sprite never tears.

Parameters:
- SCALE_SHIFT, 2, world-to-screen scale as log2 (4x: world 128x128 maps to 512x512 screen pixels).
- ICON_OFFSET, 6, screen pixels subtracted from the scaled location to get the icon top-left corner.
- COMMIT_ROW, 480, display row on which pending updates are committed (first blanking line).

Ports:
- clock  in  1  25 MHz pixel clock.
- rst  in  1  synchronous active-high reset.
- video_on  in  1  1 = active video area.
- pixel_row  in  10  current display row from the timing generator.
- pixel_column  in  10  current display column from the timing generator.
- loc_x  in  7  bot world X (0..127).
- loc_y  in  7  bot world Y (0..127).
- orient  in  3  heading: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
- upd_sysregs  in  1  one-cycle pulse: loc_x/loc_y/orient are valid.
- icon  out  2  icon code: 00 = transparent, 01/10/11 = icon colours 1/2/3.

Behaviour:
- Reset: icon=00; staging and active registers cleared (x=0, y=0, orient=0); pending=0.
- Update capture:
  - upd_sysregs=1 copies loc_x/loc_y/orient into the staging registers and sets pending=1.
  - A later pulse before commit overwrites staging (last value wins).
- Commit:
  - Occurs on the cycle where pixel_row==COMMIT_ROW, pixel_column==0 and pending=1.
  - Copies staging into the active registers and clears pending.
  - If upd_sysregs coincides with the commit cycle, the active registers take the new input values directly and pending ends at 0.
  - An update during active video never affects the current frame.
- Window arithmetic, 11-bit signed:
  - org_c = (x<<SCALE_SHIFT) - ICON_OFFSET; org_r = (y<<SCALE_SHIFT) - ICON_OFFSET.
  - dc = pixel_column - org_c; dr = pixel_row - org_r.
  - in_win = (0 <= dc < 16) and (0 <= dr < 16).
  - No wrap-around: a negative origin clips at screen edges; columns near 1023 never match.
- Sprite source:
  - Two 16x16x2 base images: N (heading 0) and NE (heading 1).
  - base = orient[0]; quarter-turns q = orient[2:1], clockwise.
  - Source (sr,sc) for output (r,c):
    - q=0 -> (r,c)
    - q=1 -> (15-c, r)
    - q=2 -> (15-r, 15-c)
    - q=3 -> (c, 15-r)
- Pipeline, fixed 2-cycle latency from pixel_row/pixel_column/video_on to icon:
  - Stage 1 registers: in_win, video_on, base, sr, sc.
  - Stage 2 registers: icon = (in_win & video_on) ? rom[base][sr][sc] : 00.
- System latency: the timing generator delays hsync/vsync by 3 clocks to cover this block (2) plus the colorizer (1).
- Reset mid-frame: the pipeline flushes to 00 on the next edge, and the sprite is drawn at (0,0) heading N until the first commit.

Decomposition:
- Shared package icon_pkg holds:
  - ICON_SIZE=16.
  - Heading codes HEAD_N..HEAD_NW.
  - Icon codes ICON_TRANSPARENT=2'b00, ICON_C1, ICON_C2, ICON_C3.
  - World-pixel codes used by the colorizer (background, line, obstruction, reserved).
- One sub-module icon_rom:
  - Synchronous read ROM, 2 images x 256 entries x 2 bits.
  - Address {base, sr[3:0], sc[3:0]}, 1-cycle registered output; this supplies stage 2.

Test Plan:
1. Reset: rst=1 for 3 cycles while sweeping pixels -> icon=00 throughout; after release with no update, sprite N appears with top-left at screen (0,0) clipped (sprite rows/cols 6..15 visible at screen 0..9).
2. loc_x=32, loc_y=32, orient=0, upd pulse, run to row 480 -> next frame, pixel (row 122..137, col 122..137) gives icon = N[r-122][c-122] two cycles later; pixels (121,130) and (130,138) give 00.
3. Mid-frame update: commit x=32; at row 200 pulse upd with x=64 -> rest of frame still at col 122; after row 480 commit, sprite at cols 250..265.
4. orient=2 (E) at loc (32,32) -> screen (122+r, 122+c) equals N[15-c][r]; orient=5 (SW) -> equals NE[15-r][15-c].
5. upd_sysregs asserted exactly at (row 480, col 0) with x=10 -> committed same cycle, pending=0; next frame sprite at cols 34..49.
6. video_on=0 while pixel in window (pos 130,130) -> icon=00 two cycles later; reasserted -> sprite value restored with same 2-cycle latency.
